// File: rtl/div_radix2.sv
// div_radix2: 32-bit radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor completes the cycle after acceptance.
module div_radix2 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_startE,
    input  logic        signed_divE,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic        stall_divE,
    output logic        ready,
    output logic [63:0] result
);
    localparam int unsigned W  = 32;
    localparam int unsigned PW = 2 * W + 1;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   count;
    logic [PW-1:0]   pr;
    logic [W-1:0]    divisor;
    logic [W-1:0]    dividend_raw;
    logic            q_neg;
    logic            r_neg;
    logic            div_zero;

    logic            load;
    logic            step;
    logic            capture;

    logic            op1_neg;
    logic            op2_neg;
    logic [W-1:0]    op1_mag;
    logic [W-1:0]    op2_mag;
    logic [PW:0]     shifted;
    logic [W+1:0]    trial;
    logic [PW-1:0]   pr_step;
    logic [W-1:0]    quot_raw;
    logic [W-1:0]    rem_raw;
    logic [W-1:0]    quot_fix;
    logic [W-1:0]    rem_fix;
    logic [2*W-1:0]  result_next;

    // Operand magnitudes; signs only matter for DIV.
    assign op1_neg = signed_divE & opdata1[W-1];
    assign op2_neg = signed_divE & opdata2[W-1];
    assign op1_mag = op1_neg ? (~opdata1 + W'(1)) : opdata1;
    assign op2_mag = op2_neg ? (~opdata2 + W'(1)) : opdata2;

    // One restoring step: shift left, trial-subtract divisor from the upper half, keep on no borrow.
    assign shifted = {pr, 1'b0};
    assign trial   = shifted[PW:W] - {2'b00, divisor};
    assign pr_step = trial[W+1] ? shifted[PW-1:0] : {trial[W:0], shifted[W-1:1], 1'b1};

    assign quot_raw = pr_step[W-1:0];
    assign rem_raw  = pr_step[2*W-1:W];
    assign quot_fix = q_neg ? (~quot_raw + W'(1)) : quot_raw;
    assign rem_fix  = r_neg ? (~rem_raw + W'(1)) : rem_raw;

    // Capture from IDLE only happens on the zero-divisor fast path.
    always_comb begin
        result_next = {rem_fix, quot_fix};
        if (state == IDLE) begin
            result_next = {opdata1, {W{1'b1}}};
        end else if (div_zero) begin
            result_next = {dividend_raw, {W{1'b1}}};
        end
    end

    assign stall_divE = div_startE & (state != DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (div_startE) begin
`ifdef DIV_ZERO_FASTPATH_EN
                    if (opdata2 == '0) begin
                        state_next = DONE;
                        capture    = 1'b1;
                    end else begin
                        state_next = BUSY;
                        load       = 1'b1;
                    end
`else
                    state_next = BUSY;
                    load       = 1'b1;
`endif
                end
            end
            BUSY: begin
                step = 1'b1;
                if (count == CW'(W - 1)) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A flush wins over everything, including a same-cycle acceptance.
        if (annul) begin
            state_next = IDLE;
            load       = 1'b0;
            step       = 1'b0;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count        <= '0;
            pr           <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            div_zero     <= 1'b0;
            result       <= '0;
            ready        <= 1'b0;
        end else begin
            ready <= capture;
            if (load) begin
                count        <= '0;
                pr           <= {(W + 1)'(0), op1_mag};
                divisor      <= op2_mag;
                dividend_raw <= opdata1;
                q_neg        <= op1_neg ^ op2_neg;
                r_neg        <= op1_neg;
                div_zero     <= (opdata2 == '0);
            end else if (step) begin
                count <= count + CW'(1);
                pr    <= pr_step;
            end
            if (capture) begin
                result <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: vector table plus annul/reset sequences for div_radix2, results checked via a scoreboard queue.
module tb_div_radix2;
    logic        clk = 1'b0;
    logic        resetn;
    logic        div_startE;
    logic        signed_divE;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        stall_divE;
    logic        ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [63:0] last_exp;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    div_radix2 dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_startE (div_startE),
        .signed_divE(signed_divE),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .stall_divE (stall_divE),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [31:0] b);
        return (b == 32'h0) ? ZLAT : 33;
    endfunction

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the rising edge that leaves DONE.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
        logic [63:0] e;
        sb.push_back(exp);
        last_exp    = exp;
        signed_divE = s;
        opdata1     = a;
        opdata2     = b;
        div_startE  = 1'b1;
        for (int cyc = 0; cyc <= lat; cyc++) begin
            @(negedge clk);
            chk($sformatf("stall c%0d %h/%h", cyc, a, b), 64'(stall_divE), 64'(cyc < lat));
            chk($sformatf("ready c%0d %h/%h", cyc, a, b), 64'(ready), 64'(cyc == lat));
            if (ready) begin
                if (sb.size() == 0) begin
                    chk("scoreboard empty on ready", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("result %h/%h s=%0d", a, b, s), result, e);
                end
            end
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                opdata1     = $urandom;
                opdata2     = $urandom;
                signed_divE = ~s;
            end
        end
        div_startE = 1'b0;
    endtask

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}};
        vecs[3]  = '{1'b0, 32'h1234_5678,  32'h0000_0000,  {32'h1234_5678, 32'hFFFF_FFFF}};
        vecs[4]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0000,  {32'hFFFF_FFF9, 32'hFFFF_FFFF}};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  {32'h0000_0000, 32'hFFFF_FFFF}};
        vecs[6]  = '{1'b0, 32'd5,          32'd10,         {32'h0000_0005, 32'h0000_0000}};
        vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}};
        vecs[8]  = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  {32'hFFFF_FFFE, 32'h0000_0002}};
        vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0000_0000}};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h0000_0001}};

        resetn      = 1'b0;
        div_startE  = 1'b0;
        signed_divE = 1'b0;
        opdata1     = '0;
        opdata2     = '0;
        annul       = 1'b0;
        last_exp    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 64'(ready), 64'(0));
        chk("reset result", result, 64'h0);
        chk("reset stall", 64'(stall_divE), 64'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            do_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, lat_of(vecs[i].b));
        end

        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 2 == 1) ? $urandom : 32'($urandom_range(1, 500));
            do_div(s, a, b, model(s, a, b), lat_of(b));
        end

        // Annul in BUSY cycle 10, then DIVU 9/3 started in cycle 12.
        sb.push_back({32'h0000_0002, 32'h0000_000E});
        signed_divE = 1'b0;
        opdata1     = 32'd100;
        opdata2     = 32'd7;
        div_startE  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(negedge clk);
        chk("annul c10 ready", 64'(ready), 64'(0));
        @(posedge clk);
        #1;
        annul      = 1'b0;
        div_startE = 1'b0;
        void'(sb.pop_front());
        @(negedge clk);
        chk("annul c11 ready", 64'(ready), 64'(0));
        chk("annul result held", result, last_exp);
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

        // Annul in the same cycle as an acceptance: nothing starts.
        signed_divE = 1'b0;
        opdata1     = 32'd50;
        opdata2     = 32'd5;
        div_startE  = 1'b1;
        annul       = 1'b1;
        @(posedge clk);
        #1;
        div_startE = 1'b0;
        annul      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("annul-accept ready c%0d", c), 64'(ready), 64'(0));
        end
        chk("annul-accept result held", result, last_exp);
        @(posedge clk);
        #1;

        // Reset in BUSY cycle 20, then a full-latency DIVU 100/7.
        signed_divE = 1'b0;
        opdata1     = 32'd100;
        opdata2     = 32'd7;
        div_startE  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
        end
        resetn     = 1'b0;
        div_startE = 1'b0;
        #1;
        chk("midbusy reset ready", 64'(ready), 64'(0));
        chk("midbusy reset result", result, 64'h0);
        @(negedge clk);
        chk("midbusy reset stall", 64'(stall_divE), 64'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33);

        @(negedge clk);
        chk("final ready low", 64'(ready), 64'(0));
        chk("final result held", result, last_exp);
        chk("scoreboard drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_radix2.md
DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port div_startE, input, 1 bit: a DIV/DIVU is in the E stage and requests a result.
REQ-004 SHALL have port signed_divE, input, 1 bit: 1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have port opdata1, input, 32 bits: dividend (rs).
REQ-006 SHALL have port opdata2, input, 32 bits: divisor (rt).
REQ-007 SHALL have port annul, input, 1 bit: abort the operation (exception flush, except_typeM != 0).
REQ-008 SHALL have port stall_divE, output, 1 bit: pipeline stall request to the hazard unit.
REQ-009 SHALL have port ready, output, 1 bit: result valid this cycle.
REQ-010 SHALL have port result, output, 64 bits: {hi = remainder, lo = quotient} for the HILO write in M.

Function
REQ-011 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-012 In IDLE with div_startE=1 and annul=0, the block SHALL latch the operand magnitudes, the quotient sign (opdata1[31]^opdata2[31], signed only) and the remainder sign (opdata1[31], signed only), clear the counter and go to BUSY.
REQ-013 In BUSY, the block SHALL perform one restoring shift-subtract step per cycle on a 65-bit partial remainder; after the 32nd step (counter 31) it SHALL go to DONE.
REQ-014 In DONE, the block SHALL assert ready=1 for exactly one cycle, with result holding the sign-corrected values, and go unconditionally to IDLE on the next cycle.
REQ-015 stall_divE SHALL be combinational: div_startE & (state != DONE).
- Cycle timing for a division accepted at cycle 0: stall_divE is 1 in cycles 0..32; ready is 1 in cycle 33.
REQ-016 result SHALL hold its last value when not in DONE, and SHALL update only on entry to DONE.
REQ-017 Operand changes after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-018 Signed correction SHALL apply as follows:
- The quotient is negated when the quotient sign is 1.
- The remainder is negated when the remainder sign is 1.
- Unsigned operations apply no correction.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000 (two's-complement wrap, no trap).
REQ-020 A divisor of 0 SHALL give lo=0xFFFFFFFF and hi=opdata1 (as latched, with no sign correction), in both signed and unsigned modes.
REQ-021 annul=1 in any state SHALL force IDLE on the next edge. Also:
- ready SHALL stay 0 and result SHALL not update.
- annul SHALL override an acceptance in the same cycle.
REQ-022 stall_divE SHALL be 0 whenever div_startE=0, in every state.

Reset
REQ-023 While resetn=0, the block SHALL asynchronously force:
- state to IDLE;
- counter to 0;
- the partial remainder to 0;
- result to 64'h0;
- ready to 0.
REQ-024 A reset asserted mid-BUSY SHALL abandon the operation. After release, a new div_startE SHALL take the full latency again.

Configuration
REQ-025 With macro DIV_ZERO_FASTPATH_EN defined, an acceptance whose divisor is 0 SHALL go IDLE->DONE directly, giving stall_divE=1 in cycle 0 only and ready=1 in cycle 1, with the REQ-020 values.
REQ-026 Without DIV_ZERO_FASTPATH_EN, a divisor of 0 SHALL take the normal 32-step path (ready in cycle 33) and give the same REQ-020 values.

Verification
REQ-027 DIVU 100/7 accepted at cycle 0: stall_divE high in cycles 0..32, ready in cycle 33, result = {hi=0x00000002, lo=0x0000000E}.
REQ-028 DIV -7/2 (0xFFFFFFF9, 0x00000002): result = {hi=0xFFFFFFFF, lo=0xFFFFFFFD}.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF: result = {hi=0x00000000, lo=0x80000000}, with no hang.
REQ-030 DIVU 0x12345678 / 0: result = {hi=0x12345678, lo=0xFFFFFFFF}; ready in cycle 1 with DIV_ZERO_FASTPATH_EN, in cycle 33 without it.
REQ-031 annul=1 in BUSY cycle 10: state is IDLE in cycle 11 and ready never pulses. A new DIVU 9/3 started in cycle 12 then gives ready in cycle 45 with {hi=0, lo=3}.
REQ-032 resetn=0 in BUSY cycle 20: outputs are immediately 0 and state is IDLE. After release, a new DIVU 100/7 matches the REQ-027 timing relative to its own start.
